wb_sevenseg: RTL and testbench

WB_SEVENSEG -- requirements
Module: wb_sevenseg

---
 rtl/wb_sevenseg_if.sv | 23 ++
 rtl/wb_sevenseg.sv | 128 ++++++++++++
 tb/tb_wb_sevenseg.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sevenseg_if.sv
// Wishbone classic bus bundle for the seven-segment scanner register block.
`timescale 1ns/1ps
interface wb_sevenseg_if;
  logic [11:2] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        wb_err;

  modport master (
    output wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, wb_stb,
    input  wb_rdt, wb_ack, wb_err
  );

  modport slave (
    input  wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, wb_stb,
    output wb_rdt, wb_ack, wb_err
  );
endinterface

// File: rtl/wb_sevenseg.sv
// Wishbone-mapped 8-digit multiplexed seven-segment driver with a programmable scan rate.
`timescale 1ns/1ps
module wb_sevenseg #(
  parameter logic [19:0] DEFAULT_DIV = 20'd100000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  wb_sevenseg_if.slave  io_wb,
  output logic [7:0]    o_an,
  output logic [6:0]    o_seg,
  output logic          o_dp
);

  logic [31:0] r_data;
  logic [31:0] r_ctrl;
  logic [19:0] r_div;
  logic [19:0] r_cnt;
  logic [2:0]  r_idx;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_rdt;
  logic [7:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;

  logic        w_req;
  logic        w_mapped;
  logic        w_wr;
  logic [31:0] w_rd_val;
  logic [31:0] w_wmask;
  logic [31:0] w_wdat;
  logic [19:0] w_div_eff;
  logic        w_wrap;
  logic [3:0]  w_digit;
  logic [6:0]  w_hex;
  logic [7:0]  w_dp_mask;
  logic [7:0]  w_an_next;

  // ack/err gate new requests so every response is followed by an idle cycle
  always_comb begin
    w_req    = io_wb.wb_cyc & io_wb.wb_stb & ~r_ack & ~r_err;
    w_mapped = (io_wb.wb_adr < 10'd4);
    w_wr     = w_req & w_mapped & io_wb.wb_we;
    w_wmask  = {{8{io_wb.wb_sel[3]}}, {8{io_wb.wb_sel[2]}},
                {8{io_wb.wb_sel[1]}}, {8{io_wb.wb_sel[0]}}};
    w_rd_val = 32'h0;
    case (io_wb.wb_adr)
      10'd0:   w_rd_val = r_data;
      10'd1:   w_rd_val = r_ctrl;
      10'd2:   w_rd_val = {12'h0, r_div};
      10'd3:   w_rd_val = {29'h0, r_idx};
      default: w_rd_val = 32'h0;
    endcase
    w_wdat    = (io_wb.wb_dat & w_wmask) | (w_rd_val & ~w_wmask);
    w_div_eff = (r_div == 20'd0) ? 20'd1 : r_div;
    w_wrap    = (r_cnt == w_div_eff - 20'd1);
  end

  always_comb begin
    w_digit   = r_data[{r_idx, 2'b00} +: 4];
    w_dp_mask = r_ctrl[15:8];
    w_an_next = (r_ctrl[31] | ~r_ctrl[r_idx]) ? 8'hFF : ~(8'd1 << r_idx);
    w_hex     = 7'h00;
    case (w_digit)
      4'h0: w_hex = 7'h3F;
      4'h1: w_hex = 7'h06;
      4'h2: w_hex = 7'h5B;
      4'h3: w_hex = 7'h4F;
      4'h4: w_hex = 7'h66;
      4'h5: w_hex = 7'h6D;
      4'h6: w_hex = 7'h7D;
      4'h7: w_hex = 7'h07;
      4'h8: w_hex = 7'h7F;
      4'h9: w_hex = 7'h6F;
      4'hA: w_hex = 7'h77;
      4'hB: w_hex = 7'h7C;
      4'hC: w_hex = 7'h39;
      4'hD: w_hex = 7'h5E;
      4'hE: w_hex = 7'h79;
      default: w_hex = 7'h71;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= 32'h0;
      r_ctrl <= 32'h0000_00FF;
      r_div  <= DEFAULT_DIV;
      r_cnt  <= 20'd0;
      r_idx  <= 3'd0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_rdt  <= 32'h0;
      r_an   <= 8'hFF;
      r_seg  <= 7'h7F;
      r_dp   <= 1'b1;
    end else begin
      r_ack <= w_req & w_mapped;
      r_err <= w_req & ~w_mapped;
      r_rdt <= (w_req & w_mapped & ~io_wb.wb_we) ? w_rd_val : 32'h0;
      r_cnt <= w_wrap ? 20'd0 : r_cnt + 20'd1;
      if (w_wrap) r_idx <= r_idx + 3'd1;
      // A DIV write restarts the count; placed after the scan step so it wins
      if (w_wr) begin
        case (io_wb.wb_adr)
          10'd0: r_data <= w_wdat;
          10'd1: r_ctrl <= w_wdat & 32'h8000_FFFF;
          10'd2: begin
            r_div <= w_wdat[19:0];
            r_cnt <= 20'd0;
          end
          default: ;
        endcase
      end
      r_an  <= w_an_next;
      r_seg <= ~w_hex;
      r_dp  <= ~w_dp_mask[r_idx];
    end
  end

  assign io_wb.wb_rdt = r_rdt;
  assign io_wb.wb_ack = r_ack;
  assign io_wb.wb_err = r_err;
  assign o_an  = r_an;
  assign o_seg = r_seg;
  assign o_dp  = r_dp;

endmodule

// File: tb/tb_wb_sevenseg.sv
// Randomized scoreboard bench for wb_sevenseg against a behavioural register/scan model.
`timescale 1ns/1ps
module tb_wb_sevenseg;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] o_an;
  logic [6:0] o_seg;
  logic       o_dp;

  always #5 i_clk = ~i_clk;

  wb_sevenseg_if wb ();

  wb_sevenseg #(.DEFAULT_DIV(20'd100000)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .io_wb (wb),
    .o_an  (o_an),
    .o_seg (o_seg),
    .o_dp  (o_dp)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [33:0] resp_q[$];

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [31:0] m_data = 32'h0;
  logic [31:0] m_ctrl = 32'hFF;
  logic [31:0] m_div  = 32'd100000;
  int          m_cnt  = 0;
  int          m_idx  = 0;
  bit          m_resp = 1'b0;
  logic [7:0]  e_an   = 8'hFF;
  logic [6:0]  e_seg  = 7'h7F;
  logic        e_dp   = 1'b1;

  task automatic check(input string nm, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: register file plus scan position, advanced once per clock
  always @(posedge i_clk) begin : model
    int d;
    int n_cnt;
    int n_idx;
    bit req;
    logic [31:0] old;
    logic [31:0] nv;
    if (i_rst) begin
      m_data <= 32'h0;
      m_ctrl <= 32'hFF;
      m_div  <= 32'd100000;
      m_cnt  <= 0;
      m_idx  <= 0;
      m_resp <= 1'b0;
      e_an   <= 8'hFF;
      e_seg  <= 7'h7F;
      e_dp   <= 1'b1;
    end else begin
      e_an  <= (!m_ctrl[31] && m_ctrl[m_idx]) ? (8'hFF ^ (8'd1 << m_idx)) : 8'hFF;
      e_seg <= ~hex_tab[m_data[4*m_idx +: 4]];
      e_dp  <= ~m_ctrl[8+m_idx];
      d     = (m_div == 32'd0) ? 1 : int'(m_div);
      n_cnt = (m_cnt + 1) % d;
      n_idx = (n_cnt == 0) ? (m_idx + 1) % 8 : m_idx;
      req   = wb.wb_cyc && wb.wb_stb && !m_resp;
      if (req) begin
        case (wb.wb_adr)
          10'd0:   old = m_data;
          10'd1:   old = m_ctrl;
          10'd2:   old = m_div;
          10'd3:   old = 32'(m_idx);
          default: old = 32'h0;
        endcase
        if (wb.wb_adr > 10'd3) begin
          resp_q.push_back({1'b0, 1'b1, 32'h0});
        end else if (wb.wb_we) begin
          nv = old;
          for (int b = 0; b < 4; b++)
            if (wb.wb_sel[b]) nv[8*b +: 8] = wb.wb_dat[8*b +: 8];
          case (wb.wb_adr)
            10'd0: m_data <= nv;
            10'd1: m_ctrl <= nv & 32'h8000_FFFF;
            10'd2: begin
              m_div <= nv & 32'h000F_FFFF;
              n_cnt = 0;
            end
            default: ;
          endcase
          resp_q.push_back({1'b1, 1'b0, 32'h0});
        end else begin
          resp_q.push_back({1'b1, 1'b0, old});
        end
      end
      m_cnt  <= n_cnt;
      m_idx  <= n_idx;
      m_resp <= req;
    end
  end

  // Monitor: display compared every cycle, bus responses popped from the scoreboard
  always @(negedge i_clk) begin
    logic [33:0] exp;
    if (mon_en) begin
      check("o_an", {26'h0, o_an}, {26'h0, e_an});
      check("o_seg", {27'h0, o_seg}, {27'h0, e_seg});
      check("o_dp", {33'h0, o_dp}, {33'h0, e_dp});
      if (wb.wb_ack || wb.wb_err) begin
        if (resp_q.size() == 0) begin
          check("unexpected_resp", {wb.wb_ack, wb.wb_err, wb.wb_rdt}, 34'h0);
        end else begin
          exp = resp_q.pop_front();
          check("resp", {wb.wb_ack, wb.wb_err, wb.wb_rdt}, exp);
        end
      end else begin
        if (resp_q.size() != 0) begin
          exp = resp_q.pop_front();
          check("missing_resp", {wb.wb_ack, wb.wb_err, wb.wb_rdt}, exp);
        end
        check("rdt_idle", {2'b00, wb.wb_rdt}, 34'h0);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic xfer(input logic [9:0] adr, input bit we, input logic [31:0] dat,
                      input logic [3:0] sel);
    bit done = 1'b0;
    wb.wb_adr = adr;
    wb.wb_we  = we;
    wb.wb_dat = dat;
    wb.wb_sel = sel;
    wb.wb_cyc = 1'b1;
    wb.wb_stb = 1'b1;
    for (int i = 0; i < 8 && !done; i++) begin
      tick();
      if (wb.wb_ack || wb.wb_err) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: adr %0d got no response, required ack or err within 8 cycles", adr);
    end
    wb.wb_cyc = 1'b0;
    wb.wb_stb = 1'b0;
    wb.wb_we  = 1'b0;
  endtask

  // Request presented on the same edge as reset: it must vanish without a response
  task automatic reset_during_req(input logic [9:0] adr);
    wb.wb_adr = adr;
    wb.wb_we  = 1'b0;
    wb.wb_cyc = 1'b1;
    wb.wb_stb = 1'b1;
    i_rst     = 1'b1;
    tick();
    wb.wb_cyc = 1'b0;
    wb.wb_stb = 1'b0;
    i_rst     = 1'b0;
  endtask

  initial begin
    logic [9:0]  r_adr;
    logic [31:0] r_dat;
    wb.wb_adr = '0;
    wb.wb_dat = '0;
    wb.wb_sel = '0;
    wb.wb_we  = 1'b0;
    wb.wb_cyc = 1'b0;
    wb.wb_stb = 1'b0;
    tick();
    mon_en = 1'b1;
    idle(2);
    i_rst = 1'b0;
    idle(1);

    xfer(10'd1, 1'b0, 32'h0, 4'hF);
    idle(2);

    xfer(10'd0, 1'b1, 32'h1234_5678, 4'hF);
    xfer(10'd2, 1'b1, 32'd4, 4'hF);
    idle(40);

    xfer(10'd0, 1'b1, 32'h0, 4'hF);
    xfer(10'd0, 1'b1, 32'hAABB_CCDD, 4'b0010);
    xfer(10'd0, 1'b0, 32'h0, 4'hF);

    xfer(10'd5, 1'b0, 32'h0, 4'hF);
    xfer(10'd5, 1'b1, 32'hFFFF_FFFF, 4'hF);
    xfer(10'd0, 1'b0, 32'h0, 4'hF);
    xfer(10'd1, 1'b0, 32'h0, 4'hF);

    xfer(10'd1, 1'b1, 32'h8000_00FF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      idle(3);
      xfer(10'd3, 1'b0, 32'h0, 4'hF);
    end
    xfer(10'd3, 1'b1, 32'hFFFF_FFFF, 4'hF);
    xfer(10'd1, 1'b1, 32'h0000_01FF, 4'hF);
    idle(40);

    // stb held high: responses must alternate with idle cycles
    wb.wb_adr = 10'd3;
    wb.wb_we  = 1'b0;
    wb.wb_cyc = 1'b1;
    wb.wb_stb = 1'b1;
    idle(7);
    wb.wb_cyc = 1'b0;
    wb.wb_stb = 1'b0;
    idle(2);

    xfer(10'd2, 1'b1, 32'd3, 4'hF);
    idle(5);
    reset_during_req(10'd1);
    idle(3);
    xfer(10'd2, 1'b1, 32'd2, 4'hF);

    for (int n = 0; n < 300; n++) begin
      r_adr = 10'($urandom_range(0, 7));
      r_dat = (r_adr == 10'd2) ? 32'($urandom_range(0, 6)) : $urandom;
      if ($urandom_range(0, 49) == 0) begin
        reset_during_req(r_adr);
        xfer(10'd2, 1'b1, 32'($urandom_range(0, 5)), 4'hF);
      end else begin
        xfer(r_adr, 1'($urandom_range(0, 1)), r_dat, 4'($urandom_range(0, 15)));
      end
      idle($urandom_range(0, 3));
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
